// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared types and constants for the instruction-fetch front end.
//             Holds the default reset vector, the fetch-slot record kept in
//             the fetch ring, and the fetch FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_pkg;

    // Default first fetch address after reset.
    localparam logic [31:0] c_RESET_PC = 32'h0000_3000;

    // Width of the killed-request counter. Several back-to-back redirects can
    // each orphan a full ring of in-flight requests before the memory drains.
    localparam int c_DROP_W = 8;

    // One ring entry: fetch address, returned instruction, and whether the
    // instruction has come back from memory yet.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        full;
    } fetch_slot_t;

    // BOOT holds off requests for one cycle after reset release.
    typedef enum logic {
        ST_BOOT  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_ring.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_ring
//  Purpose  : QDEPTH-entry slot storage for the fetch queue. Three pointers
//             walk the ring in order: tail (next slot to allocate on a request
//             accept), fill (next slot to receive a memory response) and head
//             (next slot to hand to decode). A flush rewinds all pointers and
//             clears every full bit.
//  Ports    : i_clk, i_rst_n       clock, async active-low reset
//             i_flush              rewind pointers, drop all contents
//             i_alloc, i_alloc_pc  claim tail slot for a new request
//             i_fill, i_fill_instr write returned instruction to fill slot
//             i_pop                release head slot
//             o_head_slot          current head slot contents
//  Revision : 1.0  initial release
// ============================================================================
module fetch_ring
    import cpu_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int PTR_W  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_alloc,
    input  logic [31:0] i_alloc_pc,
    input  logic        i_fill,
    input  logic [31:0] i_fill_instr,
    input  logic        i_pop,
    output fetch_slot_t o_head_slot
);

    fetch_slot_t        r_slot [QDEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W-1:0]   r_fill;

    // QDEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_slot[i] <= '0;
            end
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_slot[i].full <= 1'b0;
            end
        end else begin
            // Allocation clears full so a slot left full from an earlier lap
            // never looks valid before its own response arrives. The fill
            // slot is always already allocated, so it never equals tail
            // while an allocation is possible.
            if (i_alloc) begin
                r_slot[r_tail].pc   <= i_alloc_pc;
                r_slot[r_tail].full <= 1'b0;
                r_tail              <= r_tail + PTR_W'(1);
            end
            if (i_fill) begin
                r_slot[r_fill].instr <= i_fill_instr;
                r_slot[r_fill].full  <= 1'b1;
                r_fill               <= r_fill + PTR_W'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
        end
    end

    assign o_head_slot = r_slot[r_head];

endmodule
`default_nettype wire

// File: rtl/fetch_queue_ifu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_queue_ifu
//  Purpose  : Pipelined instruction-fetch unit. Issues sequential word
//             fetches to an in-order, variable-latency memory, buffers the
//             returned instructions with their PCs in a QDEPTH-entry ring and
//             presents them to decode over a valid/ready handshake. A
//             redirect flushes the ring and discards responses belonging to
//             requests issued before it.
//  Ports    : i_clk, i_rst_n                    clock, async active-low reset
//             o_req_valid/i_req_ready/o_req_addr fetch request channel
//             i_resp_valid/i_resp_data          in-order memory responses
//             i_redirect/i_redirect_pc          downstream control transfer
//             o_out_valid/i_out_ready           decode handshake
//             o_out_instr/o_out_pc/o_out_pc4    head instruction and PCs
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue_ifu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter int          QDEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    input  logic        i_resp_valid,
    input  logic [31:0] i_resp_data,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_instr,
    output logic [31:0] o_out_pc,
    output logic [31:0] o_out_pc4
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [31:0]           r_pc;
    logic [CNT_W-1:0]      r_alloc_cnt;   // slots in flight or filled
    logic [CNT_W-1:0]      r_live_cnt;    // live requests awaiting response
    logic [c_DROP_W-1:0]   r_drop_cnt;    // killed requests awaiting response
    logic [CNT_W-1:0]      w_alloc_next;
    logic [CNT_W-1:0]      w_live_next;
    logic [c_DROP_W-1:0]   w_drop_next;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_resp_live;
    fetch_slot_t           w_head;
    logic [1:0]            w_unused_rpc_lsb;

    assign w_unused_rpc_lsb = i_redirect_pc[1:0];

    // ------------------------------------------------------------------
    // Boot sequencing
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:  w_state_next = ST_FETCH;
            ST_FETCH: w_state_next = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign o_req_valid = (r_state == ST_FETCH) && (r_alloc_cnt < CNT_W'(QDEPTH));
    assign o_req_addr  = r_pc;
    assign w_accept    = o_req_valid && i_req_ready;

    assign o_out_valid = w_head.full && (r_alloc_cnt != '0);
    assign o_out_instr = w_head.instr;
    assign o_out_pc    = w_head.pc;
    assign o_out_pc4   = w_head.pc + 32'd4;
    assign w_pop       = o_out_valid && i_out_ready;

    // Responses are in request order, so the oldest drop_cnt of them
    // belong to killed requests.
    assign w_resp_live = i_resp_valid && (r_drop_cnt == '0);

    // ------------------------------------------------------------------
    // Credit and outstanding-request bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        w_alloc_next = r_alloc_cnt;
        w_live_next  = r_live_cnt;
        w_drop_next  = r_drop_cnt;
        if (i_redirect) begin
            // Everything still owed by memory, including a request accepted
            // this very cycle, becomes killed; a response landing now pays
            // one of them off.
            w_alloc_next = '0;
            w_live_next  = '0;
            w_drop_next  = r_drop_cnt + c_DROP_W'(r_live_cnt) + c_DROP_W'(w_accept)
                         - c_DROP_W'(i_resp_valid);
        end else begin
            if (w_accept && !w_pop) begin
                w_alloc_next = r_alloc_cnt + CNT_W'(1);
            end else if (!w_accept && w_pop) begin
                w_alloc_next = r_alloc_cnt - CNT_W'(1);
            end
            if (w_accept && !w_resp_live) begin
                w_live_next = r_live_cnt + CNT_W'(1);
            end else if (!w_accept && w_resp_live) begin
                w_live_next = r_live_cnt - CNT_W'(1);
            end
            if (i_resp_valid && (r_drop_cnt != '0)) begin
                w_drop_next = r_drop_cnt - c_DROP_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc        <= RESET_PC;
            r_alloc_cnt <= '0;
            r_live_cnt  <= '0;
            r_drop_cnt  <= '0;
        end else begin
            // A response with nothing owed means the memory broke protocol.
            if (i_resp_valid) begin
                assert ((r_drop_cnt != '0) || (r_live_cnt != '0));
            end
            r_alloc_cnt <= w_alloc_next;
            r_live_cnt  <= w_live_next;
            r_drop_cnt  <= w_drop_next;
            if (i_redirect) begin
                r_pc <= {i_redirect_pc[31:2], 2'b00};
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot storage; all ring updates are cancelled by a redirect.
    // ------------------------------------------------------------------
    fetch_ring #(
        .QDEPTH (QDEPTH),
        .PTR_W  (PTR_W)
    ) u_ring (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_redirect),
        .i_alloc      (w_accept && !i_redirect),
        .i_alloc_pc   (r_pc),
        .i_fill       (w_resp_live && !i_redirect),
        .i_fill_instr (i_resp_data),
        .i_pop        (w_pop && !i_redirect),
        .o_head_slot  (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_ifu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue_ifu
//  Purpose  : Self-checking bench for fetch_queue_ifu. An in-order memory
//             model with configurable latency answers every accepted
//             request. A reference model tracks, per redirect epoch, which
//             PCs must be requested and which instructions must reach decode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue_ifu;

    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_req_valid;
    logic        i_req_ready;
    logic [31:0] o_req_addr;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_out_instr;
    logic [31:0] o_out_pc;
    logic [31:0] o_out_pc4;

    always #5 clk = ~clk;

    fetch_queue_ifu #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_req_valid   (o_req_valid),
        .i_req_ready   (i_req_ready),
        .o_req_addr    (o_req_addr),
        .i_resp_valid  (i_resp_valid),
        .i_resp_data   (i_resp_data),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_instr   (o_out_instr),
        .o_out_pc      (o_out_pc),
        .o_out_pc4     (o_out_pc4)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_ent_t;

    typedef struct {
        logic        rr;
        logic        orr;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_ov;
        logic [31:0] exp_pc;
    } vec_t;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             lat_min = 1;
    int             lat_max = 1;
    int             last_due = 0;
    int             epoch = 0;
    int             m_alloc = 0;
    int             n_acc = 0;
    bit             m_boot = 0;
    logic [31:0]    m_req_pc;
    logic [31:0]    last_acc_addr;
    mem_ent_t       mq[$];
    logic [31:0]    m_ready[$];
    logic [31:0]    popped[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input logic rr, input logic orr, input logic rd, input logic [31:0] rpc);
        mem_ent_t e;
        logic     have;
        logic     acc;
        logic     pop;
        logic     exp_rv;
        logic     exp_ov;
        int       due;
        i_req_ready   = rr;
        i_out_ready   = orr;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        have          = 1'b0;
        e             = '{addr: 32'h0, due: 0, epoch: 0};
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            e            = mq.pop_front();
            have         = 1'b1;
            i_resp_valid = 1'b1;
            i_resp_data  = mem_word(e.addr);
        end else begin
            i_resp_valid = 1'b0;
            i_resp_data  = $urandom;
        end

        exp_rv = m_boot && (m_alloc < QDEPTH);
        chk("req_valid", {31'b0, o_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", o_req_addr, m_req_pc);
        exp_ov = (m_ready.size() > 0);
        chk("out_valid", {31'b0, o_out_valid}, {31'b0, exp_ov});
        if (exp_ov) begin
            chk("out_pc", o_out_pc, m_ready[0]);
            chk("out_instr", o_out_instr, mem_word(m_ready[0]));
            chk("out_pc4", o_out_pc4, m_ready[0] + 32'd4);
        end

        acc = o_req_valid && rr;
        pop = o_out_valid && orr;
        if (acc) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due < last_due) due = last_due;
            last_due = due;
            mq.push_back('{addr: o_req_addr, due: due, epoch: epoch});
            n_acc++;
            last_acc_addr = o_req_addr;
        end
        if (rd) begin
            m_ready.delete();
            popped.delete();
            m_alloc  = 0;
            epoch++;
            m_req_pc = {rpc[31:2], 2'b00};
        end else begin
            if (acc) begin
                m_alloc++;
                m_req_pc = m_req_pc + 32'd4;
            end
            if (pop && m_ready.size() > 0) begin
                popped.push_back(o_out_pc);
                void'(m_ready.pop_front());
                m_alloc--;
            end
            if (have && e.epoch == epoch) m_ready.push_back(e.addr);
        end
        m_boot = 1'b1;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Reset asserted for two cycles; released just after a falling edge.
    task automatic do_reset();
        rst_n         = 1'b0;
        i_req_ready   = 1'b0;
        i_out_ready   = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'h0;
        i_resp_valid  = 1'b0;
        i_resp_data   = 32'h0;
        mq.delete();
        m_ready.delete();
        popped.delete();
        m_alloc  = 0;
        m_boot   = 1'b0;
        m_req_pc = RESET_PC;
        epoch    = 0;
        last_due = 0;
        n_acc    = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", {31'b0, o_req_valid}, 32'h0);
        chk("rst_out_valid", {31'b0, o_out_valid}, 32'h0);
        chk("rst_out_pc", o_out_pc, 32'h0);
        chk("rst_out_instr", o_out_instr, 32'h0);
        chk("rst_out_pc4", o_out_pc4, 32'h4);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vt[6];
        vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0,    1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'h3000, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 32'h3004, 1'b0, 32'h0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 32'h3008, 1'b1, 32'h3000};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h300C, 1'b1, 32'h3004};
        vt[5] = '{1'b1, 1'b1, 1'b1, 32'h3010, 1'b1, 32'h3008};

        @(negedge clk);

        // Startup, latency 1: first instruction three cycles after release.
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            chk("tbl_req_valid", {31'b0, o_req_valid}, {31'b0, vt[i].exp_rv});
            if (vt[i].exp_rv) chk("tbl_req_addr", o_req_addr, vt[i].exp_addr);
            chk("tbl_out_valid", {31'b0, o_out_valid}, {31'b0, vt[i].exp_ov});
            if (vt[i].exp_ov) begin
                chk("tbl_out_pc", o_out_pc, vt[i].exp_pc);
                chk("tbl_out_pc4", o_out_pc4, vt[i].exp_pc + 32'd4);
            end
            step(vt[i].rr, vt[i].orr, 1'b0, 32'h0);
        end

        // Full ring: decode stalled, latency 2.
        lat_min = 2; lat_max = 2;
        do_reset();
        repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("full_n_acc", n_acc, 4);
        chk("full_last_addr", last_acc_addr, 32'h300C);
        chk("full_req_valid", {31'b0, o_req_valid}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("after_pop_req_valid", {31'b0, o_req_valid}, 32'h1);
        chk("after_pop_addr", o_req_addr, 32'h3010);

        // Memory back-pressure: address held, no PC skip.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_addr", o_req_addr, 32'h3008);
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_pop_count_ge4", {31'b0, popped.size() >= 4}, 32'h1);
        if (popped.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("stall_order", popped[i], 32'h3000 + 32'(4 * i));
        end

        // Redirect with two stale requests in flight, latency 3.
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h3403);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_popped", {31'b0, popped.size() > 0}, 32'h1);
        if (popped.size() > 0) chk("redir_first_pc", popped[0], 32'h3400);

        // Redirect coinciding with a pop and a request accept.
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("coll_out_valid_before", {31'b0, o_out_valid}, 32'h1);
        chk("coll_req_valid_before", {31'b0, o_req_valid}, 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h5000);
        chk("coll_out_valid_after", {31'b0, o_out_valid}, 32'h0);
        chk("coll_req_addr_after", o_req_addr, 32'h5000);
        repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("coll_popped", {31'b0, popped.size() > 0}, 32'h1);
        if (popped.size() > 0) chk("coll_first_pc", popped[0], 32'h5000);

        // PC wrap at the top of the address space.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_popped", {31'b0, popped.size() >= 3}, 32'h1);
        if (popped.size() >= 3) begin
            chk("wrap_pc0", popped[0], 32'hFFFF_FFFC);
            chk("wrap_pc1", popped[1], 32'h0000_0000);
            chk("wrap_pc2", popped[2], 32'h0000_0004);
        end

        // Randomized traffic with a mid-run reset.
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            step($urandom_range(99, 0) < 70,
                 $urandom_range(99, 0) < 60,
                 $urandom_range(99, 0) < 3,
                 $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue_ifu.md
Name: fetch_queue_ifu

Overview:
- Pipelined instruction-fetch unit, successor to the single-cycle fetch stage.
- Generates sequential PCs from a parametrised reset vector and issues requests to a variable-latency, in-order instruction memory.
- Buffers returned instructions with their PCs in a QDEPTH-entry ring and hands them to decode over a valid/ready handshake.
- Accepts redirects (branch/j/jr resolved downstream) that flush the buffer and discard in-flight responses.

Parameters:
- RESET_PC, 32'h00003000, first fetch address after reset.
- QDEPTH, 4, ring entries; power of two, 2..16; also the cap on allocated (in-flight + filled) slots.
- PTR_W, $clog2(QDEPTH), pointer width, derived.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Req_Valid  out  1  fetch request valid.
- Req_Ready  in  1  memory accepts request.
- Req_Addr  out  32  word-aligned fetch address.
- Resp_Valid  in  1  instruction returned, in request order, ≥1 cycle after acceptance.
- Resp_Data  in  32  returned instruction.
- Redirect  in  1  taken branch/jump from downstream.
- Redirect_PC  in  32  new fetch address.
- Out_Valid  out  1  head entry holds a filled instruction.
- Out_Ready  in  1  decode consumes head.
- Out_Instr  out  32  head instruction.
- Out_PC  out  32  head PC.
- Out_PC4  out  32  Out_PC + 4, mod 2^32.

Behaviour:
- Reset (async assert, sync-released flops): pc=RESET_PC; head, tail and fill pointers = 0; alloc_cnt=0; drop_cnt=0; state=BOOT.
  - Outputs during and after reset: Req_Valid=0, Out_Valid=0, Out_Instr/Out_PC=0, Out_PC4=4.
- FSM:
  - BOOT lasts exactly one cycle after Reset_n rises, with no requests; then FETCH.
  - FETCH is permanent until reset.
- Request issue:
  - In FETCH, Req_Valid=1 whenever alloc_cnt<QDEPTH; Req_Addr=pc.
  - On Req_Valid&&Req_Ready: slot[tail].pc=pc, slot[tail].full=0, tail++, alloc_cnt++, pc<=pc+4 (wraps at 2^32).
  - Req_Valid may drop only when the buffer is full; Req_Addr is held while Req_Valid=1 and not accepted.
- Response:
  - On Resp_Valid with drop_cnt>0: drop_cnt--, data discarded.
  - Otherwise: slot[fill].instr=Resp_Data, full=1, fill++.
  - A response with no live or killed request outstanding is a protocol error; assert in simulation only.
- Output:
  - Out_Valid = slot[head].full && alloc_cnt>0, combinational from registers.
  - Out_Instr/Out_PC come from slot[head].
  - On Out_Valid&&Out_Ready: head++, alloc_cnt--.
  - Zero-latency pass-through from Resp to Out in the same cycle is not required; minimum fetch-to-Out latency is memory latency + 1.
- Redirect (highest priority, applies at the clock edge):
  - pc <= {Redirect_PC[31:2],2'b00}.
  - head, tail and fill pointers reset to 0; alloc_cnt=0; all full bits cleared.
  - drop_cnt <= drop_cnt + (requests accepted but not yet responded, including one accepted this cycle) − (response arriving this cycle).
  - Any pop or push in the redirect cycle is cancelled.
  - Req_Valid in the redirect cycle still presents the old pc; if accepted, that request is counted as killed.
  - New-path requests start the following cycle.
- Simultaneous accept + pop: alloc_cnt unchanged.
- Full: alloc_cnt==QDEPTH → Req_Valid=0 until a pop.
- Empty/unfilled head: Out_Valid=0, Out_Instr/Out_PC hold the last slot contents (don't-care to decode).
- Reset mid-operation: all state cleared immediately; in-flight responses after release are the memory's responsibility (memory is reset by the same Reset_n).

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC default.
  - The fetch slot struct {pc, instr, full}.
  - FSM state enum {BOOT, FETCH}.
- One natural sub-module: fetch_ring, the QDEPTH slot storage with alloc/fill/pop pointers and flush.
- The PC/credit/drop-counter logic stays in the top.

Test Plan:
- Reset release, memory latency 1, Out_Ready=1 → requests 0x3000, 0x3004, …; Out_PC=0x3000 with Out_PC4=0x3004 first appears 3 cycles after Reset_n rises; then one instruction per cycle.
- Out_Ready=0, latency 2, QDEPTH=4 → exactly 4 requests accepted (0x3000–0x300C), then Req_Valid=0; after one pop, next request is 0x3010.
- Req_Ready low for 3 cycles → Req_Addr held at 0x3008, no PC skip, Out order unchanged.
- Latency 3 with 2 in flight, Redirect=1, Redirect_PC=0x3403 → the 2 stale responses are dropped; next Out_PC=0x3400; no stale PC ever appears on Out.
- Redirect in the same cycle as an Out pop and a request accept → pop cancelled, accepted request killed (drop_cnt includes it), alloc_cnt=0.
- pc=0xFFFFFFFC sequential fetch → next Req_Addr=0x00000000; Out_PC4 at 0xFFFFFFFC reads 0x00000000.
